// File: rtl/posedge_univ_shift_reg.sv
// posedge_univ_shift_reg: rising-edge W-bit universal shift register (hold, shift right, shift left, load).
// Each master-slave bit pair is written as one rising-edge flop, since that is its net behaviour.
module posedge_univ_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   mode,
    input  logic         sin_r,
    input  logic         sin_l,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         sout_r,
    output logic         sout_l
);
    logic [W-1:0] shr, shl, nxt;
    generate
        if (W == 1) begin : g_one
            assign shr = sin_r;
            assign shl = sin_l;
        end else begin : g_many
            assign shr = {sin_r, q[W-1:1]};
            assign shl = {q[W-2:0], sin_l};
        end
    endgenerate
    always_comb nxt = mode[1] ? (mode[0] ? d : shl) : (mode[0] ? shr : q);
    always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else     q <= nxt;
    end
    assign sout_r = q[0];
    assign sout_l = q[W-1];
endmodule

// File: doc/posedge_univ_shift_reg.md
# posedge_univ_shift_reg

Rising-edge, W-bit universal shift register. It is the positive-edge counterpart to the team's negative-edge master-slave flop: every bit is a rising-edge master-slave stage, with its next-state selection done by 2:1 mux selection. It provides hold, shift-right, shift-left and parallel-load modes. Serial outputs are provided at both ends, so instances can be chained into wider registers or used as serializer/deserializer front-ends.

## Interface
Parameters:
- W, default 4: register width in bits; legal range 1..32.

Ports:
- clk, input, 1: clock; all state changes on the rising edge only.
- rst, input, 1: synchronous reset, active-high; sampled on the rising edge of clk.
- mode, input, 2: operation select. 2'b00 hold, 2'b01 shift right, 2'b10 shift left, 2'b11 parallel load.
- sin_r, input, 1: serial input for shift right; enters at bit W-1.
- sin_l, input, 1: serial input for shift left; enters at bit 0.
- d, input, W: parallel load data.
- q, output, W: register contents (slave outputs).
- sout_r, output, 1: bit shifted out by shift right; equals q[0].
- sout_l, output, 1: bit shifted out by shift left; equals q[W-1].

## Operation
- Each bit is a master-slave pair:
  - Master is transparent while clk=0 and holds while clk=1.
  - Slave is transparent while clk=1 and holds while clk=0.
  - Net effect: q changes only at the rising edge.
- Next-state selection per bit i, from a mux tree on mode:
  - hold: q[i] keeps its value.
  - shift right: q[i] takes q[i+1]; q[W-1] takes sin_r.
  - shift left: q[i] takes q[i-1]; q[0] takes sin_l.
  - load: q[i] takes d[i].
- Reset:
  - rst=1 at a rising edge forces q to 0, regardless of mode, d and the serial inputs.
  - rst gates the master inputs only; it is not asynchronous.
- sout_r and sout_l are purely combinational taps of q. They have no extra register stage.
- W=1:
  - Shift right: q takes sin_r.
  - Shift left: q takes sin_l.
  - sout_r and sout_l both equal q[0].
- Chaining:
  - Connect the upper instance's sout_r to the lower instance's sin_r.
  - Connect the lower instance's sout_l to the upper instance's sin_l.
  - Driven with the same mode, the chain behaves as a single 2W register.

## Timing
- Reset value: q = 0, sout_r = 0, sout_l = 0. These hold from the first rising edge with rst=1 until the first rising edge with rst=0.
- Before the first reset edge, q is X.
- Latency:
  - Any mode takes effect at the rising edge where it is sampled; q shows the result right after that edge. Latency is 1 cycle.
  - A parallel-loaded word is fully visible 1 cycle after the load edge.
  - Its last bit exits sout_r after W-1 further shift-right edges.
- Input sampling and stability:
  - mode, d, sin_r and sin_l are sampled at the rising edge only.
  - Changes while clk=1 must not affect q; the master is closed during that phase.
  - Changes while clk=0 are absorbed by the master and do not reach q until the next rising edge.
- Simultaneous events:
  - rst wins over every mode.
  - rst asserted mid-shift-sequence clears q at that edge. The sequence does not resume; the next non-reset edge operates on q=0.
- No wrap-around or rotate mode: bits leaving the register are lost unless fed back externally through sin_r or sin_l.
- The clk=1 phase and the clk=0 phase must each exceed the latch transparency delay. No other clock-ratio constraint applies.

## Test plan
- Reset: drive rst=1 with mode=11 and d=4'hF, then apply one rising edge. Required: q=4'h0, sout_r=0, sout_l=0. Hold rst=1 for 3 more edges; q stays 4'h0.
- Load and hold:
  - Load d=4'hA (mode=11), then set mode=00 for 4 edges. Required: q=4'hA throughout.
  - Toggle d to 4'h5 while clk=1 and while clk=0 during the hold edges. Required: q is unchanged.
- Shift right: load 4'hB, then shift right 4 edges with sin_r=0. Required:
  - q sequence: 4'h5, 4'h2, 4'h1, 4'h0.
  - sout_r sequence: 1, 1, 0, 1, taken before each edge.
- Shift left: load 4'h3, then shift left 3 edges with sin_l=1. Required:
  - q sequence: 4'h7, 4'hF, 4'hF.
  - sout_l: 0 after the load, 0 after edge 1, then 1 after edge 2 and after edge 3.
- Reset mid-shift: load 4'hC and shift right once (q=4'h6). Assert rst together with mode=01 at the next edge. Required: q=4'h0. The next edge with rst=0, mode=01 and sin_r=1 gives q=4'h8.
- Chain and W=1:
  - Two W=4 instances chained as one 8-bit register: load 8'h81, shift left once with sin_l=0. Required: combined q=8'h02.
  - Separately, a W=1 instance with shift right and sin_r=1. Required: q=1 and sout_l=1.
